// File: rtl/flt_pipe.sv
// Pipelined IEEE-754 less-than comparator (single or double precision) with operand delay lines.
// Define FLT_NAN_CHECK_EN to force an unordered (0) result whenever either operand is NaN.
module flt_pipe #(
    parameter int DataWidth = 32,
    parameter int Depth     = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DataWidth-1:0]       a,
    input  logic [DataWidth-1:0]       b,
    input  logic                       go,
    input  logic                       pipeEn,
    output logic                       result,
    output logic                       rdy,
    output logic [DataWidth-1:0]       a_dly,
    output logic [DataWidth-1:0]       b_dly,
    output logic [DataWidth*Depth-1:0] a_wdout,
    output logic [DataWidth*Depth-1:0] b_wdout
);

    localparam int MagWidth = DataWidth - 1;

    typedef struct packed {
        logic sign_a;
        logic sign_b;
        logic mag_lt;
        logic mag_gt;
        logic both_zero;
        logic nan;
    } cmp_flags_t;

`ifdef FLT_NAN_CHECK_EN
    localparam int ExpWidth = (DataWidth == 64) ? 11 : 8;
    localparam int ManWidth = DataWidth - 1 - ExpWidth;

    function automatic logic is_nan(input logic [DataWidth-1:0] v);
        return (&v[DataWidth-2 -: ExpWidth]) && (|v[ManWidth-1:0]);
    endfunction
`endif

    // Final ordering decision; +0/-0 collapse to equal, negatives order by reversed magnitude.
    function automatic logic decide(input cmp_flags_t f);
        logic lt;
        if (f.nan || f.both_zero) begin
            lt = 1'b0;
        end else if (f.sign_a != f.sign_b) begin
            lt = f.sign_a;
        end else if (f.sign_a) begin
            lt = f.mag_gt;
        end else begin
            lt = f.mag_lt;
        end
        return lt;
    endfunction

    logic [MagWidth-1:0] mag_a;
    logic [MagWidth-1:0] mag_b;
    cmp_flags_t          in_flags;

    assign mag_a = a[MagWidth-1:0];
    assign mag_b = b[MagWidth-1:0];

    always_comb begin
        in_flags           = '0;
        in_flags.sign_a    = a[DataWidth-1];
        in_flags.sign_b    = b[DataWidth-1];
        in_flags.mag_lt    = (mag_a < mag_b);
        in_flags.mag_gt    = (mag_a > mag_b);
        in_flags.both_zero = (mag_a == '0) && (mag_b == '0);
`ifdef FLT_NAN_CHECK_EN
        in_flags.nan       = is_nan(a) || is_nan(b);
`endif
    end

    logic [DataWidth-1:0] a_pipe [Depth];
    logic [DataWidth-1:0] b_pipe [Depth];
    logic [Depth-1:0]     go_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                a_pipe[i] <= '0;
                b_pipe[i] <= '0;
            end
            go_pipe <= '0;
        end else if (pipeEn) begin
            a_pipe[0]  <= a;
            b_pipe[0]  <= b;
            go_pipe[0] <= go;
            for (int i = 1; i < Depth; i++) begin
                a_pipe[i]  <= a_pipe[i-1];
                b_pipe[i]  <= b_pipe[i-1];
                go_pipe[i] <= go_pipe[i-1];
            end
        end
    end

    assign a_dly = a_pipe[Depth-1];
    assign b_dly = b_pipe[Depth-1];
    assign rdy   = go_pipe[Depth-1];

    for (genvar g = 0; g < Depth; g++) begin : g_wd
        assign a_wdout[g*DataWidth +: DataWidth] = a_pipe[g];
        assign b_wdout[g*DataWidth +: DataWidth] = b_pipe[g];
    end

    // With Depth >= 2 the compare flags are registered in stage 0 and decided one stage later.
    if (Depth == 1) begin : g_res_single
        logic res_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= 1'b0;
            end else if (pipeEn) begin
                res_q <= decide(in_flags);
            end
        end

        assign result = res_q;
    end else begin : g_res_multi
        cmp_flags_t       flags_q;
        logic [Depth-2:0] res_pipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                flags_q  <= '0;
                res_pipe <= '0;
            end else if (pipeEn) begin
                flags_q     <= in_flags;
                res_pipe[0] <= decide(flags_q);
                for (int i = 1; i < Depth - 1; i++) begin
                    res_pipe[i] <= res_pipe[i-1];
                end
            end
        end

        assign result = res_pipe[Depth-2];
    end

endmodule

// File: tb/tb_flt_pipe.sv
// Self-checking bench for flt_pipe: single precision (Depth 3) and double precision (Depth 2) side by side.
// Reference model orders values as signed integers built from sign and magnitude.
module tb_flt_pipe;

    localparam int D32 = 3;
    localparam int D64 = 2;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        go;
        logic        lt;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] a32, b32, ad32, bd32;
    logic        go32, en32, res32, rdy32;
    logic [95:0] aw32, bw32;

    logic [63:0]  a64, b64, ad64, bd64;
    logic         go64, en64, res64, rdy64;
    logic [127:0] aw64, bw64;

    int checks = 0;
    int errors = 0;

    item_t q32[$];
    item_t q64[$];

    logic [31:0] va_q[$];
    logic [31:0] vb_q[$];
    logic        ve_q[$];

    always #5 clk = ~clk;

    flt_pipe #(.DataWidth(32), .Depth(D32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .go(go32), .pipeEn(en32),
        .result(res32), .rdy(rdy32), .a_dly(ad32), .b_dly(bd32),
        .a_wdout(aw32), .b_wdout(bw32)
    );

    flt_pipe #(.DataWidth(64), .Depth(D64)) dut64 (
        .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .go(go64), .pipeEn(en64),
        .result(res64), .rdy(rdy64), .a_dly(ad64), .b_dly(bd64),
        .a_wdout(aw64), .b_wdout(bw64)
    );

    function automatic logic ref_nan(input logic [63:0] x, input int w);
        int          ew;
        logic [63:0] ex;
        logic [63:0] man_mask;
        ew       = (w == 64) ? 11 : 8;
        ex       = (x >> (w - 1 - ew)) & ((64'd1 << ew) - 64'd1);
        man_mask = (64'd1 << (w - 1 - ew)) - 64'd1;
        return (ex == ((64'd1 << ew) - 64'd1)) && ((x & man_mask) != 64'd0);
    endfunction

    function automatic logic ref_lt(input logic [63:0] x, input logic [63:0] y, input int w);
        logic [63:0] mag_mask;
        longint      vx, vy;
        mag_mask = (64'd1 << (w - 1)) - 64'd1;
        vx = x[w-1] ? -longint'(x & mag_mask) : longint'(x & mag_mask);
        vy = y[w-1] ? -longint'(y & mag_mask) : longint'(y & mag_mask);
`ifdef FLT_NAN_CHECK_EN
        if (ref_nan(x, w) || ref_nan(y, w)) return 1'b0;
`else
        if (ref_nan(x, w) && ref_nan(y, w) && 1'b0) return 1'b0;
`endif
        return vx < vy;
    endfunction

    function automatic logic [127:0] exp_wd32(input logic sel_b);
        logic [127:0] r;
        int           idx;
        r = '0;
        for (int i = 0; i < D32; i++) begin
            idx = q32.size() - 1 - i;
            if (idx >= 0)
                r |= {96'd0, (sel_b ? q32[idx].b[31:0] : q32[idx].a[31:0])} << (i * 32);
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_wd64(input logic sel_b);
        logic [127:0] r;
        int           idx;
        r = '0;
        for (int i = 0; i < D64; i++) begin
            idx = q64.size() - 1 - i;
            if (idx >= 0)
                r |= {64'd0, (sel_b ? q64[idx].b : q64[idx].a)} << (i * 64);
        end
        return r;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        item_t e32, e64;
        e32 = (q32.size() == D32) ? q32[0] : '0;
        e64 = (q64.size() == D64) ? q64[0] : '0;
        check1("res32", res32, e32.lt);
        check1("rdy32", rdy32, e32.go);
        check64("adly32", {32'd0, ad32}, {32'd0, e32.a[31:0]});
        check64("bdly32", {32'd0, bd32}, {32'd0, e32.b[31:0]});
        check128("awd32", {32'd0, aw32}, exp_wd32(1'b0));
        check128("bwd32", {32'd0, bw32}, exp_wd32(1'b1));
        check1("res64", res64, e64.lt);
        check1("rdy64", rdy64, e64.go);
        check64("adly64", ad64, e64.a);
        check64("bdly64", bd64, e64.b);
        check128("awd64", aw64, exp_wd64(1'b0));
        check128("bwd64", bw64, exp_wd64(1'b1));
    endtask

    // One clock step on both DUTs; the model only advances on enabled edges.
    task automatic apply_stimulus(input logic [31:0] sa, input logic [31:0] sb, input logic sgo, input logic sen,
                                  input logic [63:0] da, input logic [63:0] db, input logic dgo, input logic den);
        item_t it;
        a32 = sa; b32 = sb; go32 = sgo; en32 = sen;
        a64 = da; b64 = db; go64 = dgo; en64 = den;
        @(posedge clk);
        if (sen) begin
            it.a = {32'd0, sa}; it.b = {32'd0, sb}; it.go = sgo;
            it.lt = ref_lt({32'd0, sa}, {32'd0, sb}, 32);
            q32.push_back(it);
            if (q32.size() > D32) void'(q32.pop_front());
        end
        if (den) begin
            it.a = da; it.b = db; it.go = dgo; it.lt = ref_lt(da, db, 64);
            q64.push_back(it);
            if (q64.size() > D64) void'(q64.pop_front());
        end
        #1;
        check_output();
    endtask

    task automatic step32(input logic [31:0] sa, input logic [31:0] sb, input logic sgo, input logic sen);
        apply_stimulus(sa, sb, sgo, sen, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic step64(input logic [63:0] da, input logic [63:0] db, input logic dgo, input logic den);
        apply_stimulus(32'd0, 32'd0, 1'b0, 1'b0, da, db, dgo, den);
    endtask

    // Back-to-back vectors from va_q/vb_q with spec-given expected results in ve_q.
    task automatic run_vectors32(input string tag);
        int n;
        n = va_q.size();
        for (int k = 0; k < n + D32 - 1; k++) begin
            if (k < n) step32(va_q[k], vb_q[k], 1'b1, 1'b1);
            else       step32(32'd0, 32'd0, 1'b0, 1'b1);
            if (k >= D32 - 1) begin
                check1($sformatf("%s_res_%0d", tag, k - D32 + 1), res32, ve_q[k - D32 + 1]);
                check1($sformatf("%s_rdy_%0d", tag, k - D32 + 1), rdy32, 1'b1);
                check64($sformatf("%s_adly_%0d", tag, k - D32 + 1), {32'd0, ad32}, {32'd0, va_q[k - D32 + 1]});
            end
        end
        va_q.delete(); vb_q.delete(); ve_q.delete();
    endtask

    function automatic logic [31:0] rand32();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7f80_0000;
            3:       return 32'hff80_0000;
            4:       return 32'h7fc0_0000 | ($urandom & 32'h0000_ffff);
            5:       return $urandom & 32'h807f_ffff;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 9))
            0:       return 64'h0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'h7ff0_0000_0000_0000;
            3:       return 64'hfff0_0000_0000_0000;
            4:       return 64'h7ff8_0000_0000_0000 | {32'd0, $urandom};
            5:       return {$urandom & 32'h800f_ffff, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] xa, xb;

        rst_n = 1'b1;
        a32 = '0; b32 = '0; go32 = 1'b0; en32 = 1'b0;
        a64 = '0; b64 = '0; go64 = 1'b0; en64 = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_output();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back single-precision pairs
        va_q = '{32'h3f6d24f7, 32'h3f06c8af, 32'h3e9e9b9a, 32'h3f0090de};
        vb_q = '{32'h3fdbad77, 32'h3f0ded69, 32'h3e4488e1, 32'h3f012260};
        ve_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        run_vectors32("b2b");

        // Sign and zero handling
        va_q = '{32'hbf800000, 32'hbf800000, 32'h80000000, 32'h00000000, 32'h3f800000};
        vb_q = '{32'h3f800000, 32'hc0000000, 32'h00000000, 32'h80000000, 32'h3f800000};
        ve_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_vectors32("sign");

        // NaN handling depends on the build option
`ifdef FLT_NAN_CHECK_EN
        va_q = '{32'h7fc00000, 32'h3f800000, 32'hff800001};
        vb_q = '{32'h3f800000, 32'h7fc00000, 32'h00000000};
        ve_q = '{1'b0, 1'b0, 1'b0};
`else
        va_q = '{32'hff800001};
        vb_q = '{32'h00000000};
        ve_q = '{1'b1};
`endif
        run_vectors32("nan");

        // Stall: the pair must emerge after exactly two more enabled edges
        step32(32'h3f800000, 32'h40000000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step32($urandom, $urandom, 1'b1, 1'b0);
            check1("stall_rdy", rdy32, 1'b0);
        end
        step32(32'd0, 32'd0, 1'b0, 1'b1);
        check1("stall_rdy_early", rdy32, 1'b0);
        step32(32'd0, 32'd0, 1'b0, 1'b1);
        check1("stall_res", res32, 1'b1);
        check1("stall_rdy", rdy32, 1'b1);
        check64("stall_bdly", {32'd0, bd32}, 64'h4000_0000);

        // Double precision
        step64(64'h3ff0000000000000, 64'h4000000000000000, 1'b1, 1'b1);
        step64(64'hc000000000000000, 64'hbff0000000000000, 1'b1, 1'b1);
        check1("dbl_res_0", res64, 1'b1);
        check1("dbl_rdy_0", rdy64, 1'b1);
        step64(64'd0, 64'd0, 1'b0, 1'b1);
        check1("dbl_res_1", res64, 1'b1);
        check64("dbl_adly_1", ad64, 64'hc000000000000000);

        // Reset mid-flight with two valid items in each pipe
        apply_stimulus(32'h3f800000, 32'h40000000, 1'b1, 1'b1, 64'h3ff0000000000000, 64'h4000000000000000, 1'b1, 1'b1);
        apply_stimulus(32'hbf800000, 32'h3f800000, 1'b1, 1'b1, 64'hc000000000000000, 64'hbff0000000000000, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        q32.delete();
        q64.delete();
        check1("rst_rdy32", rdy32, 1'b0);
        check1("rst_res32", res32, 1'b0);
        check64("rst_adly32", {32'd0, ad32}, 64'd0);
        check64("rst_bdly32", {32'd0, bd32}, 64'd0);
        check1("rst_rdy64", rdy64, 1'b0);
        check_output();
        @(posedge clk);
        #1 check_output();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(32'h3f800000, 32'h40000000, 1'b0, 1'b1, 64'h0, 64'h1, 1'b0, 1'b1);
            check1("post_rst_rdy32", rdy32, 1'b0);
        end

        // Randomized traffic with random stalls on both pipes
        for (int i = 0; i < 300; i++) begin
            ra = rand32();
            rb = ($urandom_range(0, 5) == 0) ? ra : rand32();
            xa = rand64();
            xb = ($urandom_range(0, 5) == 0) ? xa : rand64();
            apply_stimulus(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                           xa, xb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
